// File: rtl/hex_disp_pkg.sv
// Shared types and constants for the 7-segment score display path.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package hex_disp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CONV,
        SCAN,
        DASH,
        COMMIT
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // Largest value that fits in num_digits decimal digits (10^n - 1).
    function automatic int max_val(input int num_digits);
        int v;
        v = 1;
        for (int i = 0; i < num_digits; i++) begin
            v = v * 10;
        end
        return v - 1;
    endfunction

endpackage

// File: rtl/hex_disp_dec.sv
// Hex nibble to active-low 7-segment decoder (purely combinational).
// en=0 turns the digit off.
module hex_disp_dec
    import hex_disp_pkg::*;
(
    input  logic       en,
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (en) begin
            case (hex)
                4'h0: seg = 7'b1000000;
                4'h1: seg = 7'b1111001;
                4'h2: seg = 7'b0100100;
                4'h3: seg = 7'b0110000;
                4'h4: seg = 7'b0011001;
                4'h5: seg = 7'b0010010;
                4'h6: seg = 7'b0000010;
                4'h7: seg = 7'b1111000;
                4'h8: seg = 7'b0000000;
                4'h9: seg = 7'b0010000;
                4'hA: seg = 7'b0001000;
                4'hB: seg = 7'b0000011;
                4'hC: seg = 7'b1000110;
                4'hD: seg = 7'b0100001;
                4'hE: seg = 7'b0000110;
                4'hF: seg = 7'b0001110;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/hex_score_disp_ctrl.sv
// Score/level display sequencer: binary in, serial BCD conversion, one shared
// decoder scanned over all digits, tear-free commit. Optional blink: HEX_SCORE_DISP_BLINK_EN.
module hex_score_disp_ctrl
    import hex_disp_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int BIN_W      = 14
`ifdef HEX_SCORE_DISP_BLINK_EN
    ,
    parameter int BLINK_HALF = 25_000_000
`endif
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        load_valid,
    output logic                        load_ready,
    input  logic [BIN_W-1:0]            load_value,
    input  logic                        blank_lz,
    input  logic                        disp_en,
`ifdef HEX_SCORE_DISP_BLINK_EN
    input  logic                        blink,
`endif
    output logic                        busy,
    output logic                        overflow,
    output logic [NUM_DIGITS-1:0][6:0]  seg_out
);

    localparam logic [BIN_W:0] MAX_VAL = (BIN_W+1)'(max_val(NUM_DIGITS));
    localparam int CW = $clog2(BIN_W + 1);
    localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    state_t                       state_reg;
    logic [BIN_W-1:0]             bin_reg;
    logic [NUM_DIGITS-1:0][3:0]   bcd_reg;
    logic [4*NUM_DIGITS-1:0]      bcd_adj;
    logic [NUM_DIGITS-1:0]        lz_zero;
    logic                         blank_lz_reg;
    logic                         ovf_path_reg;
    logic [CW-1:0]                bit_cnt_reg;
    logic [DW-1:0]                dig_cnt_reg;
    logic [NUM_DIGITS-1:0][6:0]   shadow_reg;
    logic [NUM_DIGITS-1:0][6:0]   seg_reg;
    logic                         busy_reg;
    logic                         ready_reg;
    logic                         ovf_reg;
    logic [6:0]                   dec_seg;
    logic                         scan_blank;
    logic                         show;

    // Add-3 correction applied to every nibble before each shift.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
            assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi] >= 4'd5) ? (bcd_reg[gi] + 4'd3) : bcd_reg[gi];
        end
    endgenerate

    // lz_zero[k]: digit k and every more significant digit are zero.
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
            assign lz_zero[gi] = (bcd_reg[NUM_DIGITS-1:gi] == '0);
        end
    endgenerate

    hex_disp_dec u_dec (
        .en  (1'b1),
        .hex (bcd_reg[dig_cnt_reg]),
        .seg (dec_seg)
    );

    assign scan_blank = blank_lz_reg && (dig_cnt_reg != '0) && lz_zero[dig_cnt_reg];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            bin_reg      <= '0;
            bcd_reg      <= '0;
            blank_lz_reg <= 1'b0;
            ovf_path_reg <= 1'b0;
            bit_cnt_reg  <= '0;
            dig_cnt_reg  <= '0;
            shadow_reg   <= {NUM_DIGITS{SEG_BLANK}};
            seg_reg      <= {NUM_DIGITS{SEG_BLANK}};
            busy_reg     <= 1'b0;
            ready_reg    <= 1'b1;
            ovf_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (load_valid) begin
                        bin_reg      <= load_value;
                        bcd_reg      <= '0;
                        blank_lz_reg <= blank_lz;
                        bit_cnt_reg  <= '0;
                        dig_cnt_reg  <= '0;
                        busy_reg     <= 1'b1;
                        ready_reg    <= 1'b0;
                        if ({1'b0, load_value} > MAX_VAL) begin
                            ovf_path_reg <= 1'b1;
                            state_reg    <= DASH;
                        end else begin
                            ovf_path_reg <= 1'b0;
                            state_reg    <= CONV;
                        end
                    end
                end
                CONV: begin
                    bcd_reg     <= (bcd_adj << 1) | (4*NUM_DIGITS)'(bin_reg[BIN_W-1]);
                    bin_reg     <= bin_reg << 1;
                    bit_cnt_reg <= bit_cnt_reg + CW'(1);
                    if (bit_cnt_reg == CW'(BIN_W - 1)) begin
                        state_reg <= SCAN;
                    end
                end
                SCAN: begin
                    shadow_reg[dig_cnt_reg] <= scan_blank ? SEG_BLANK : dec_seg;
                    if (dig_cnt_reg == DW'(NUM_DIGITS - 1)) begin
                        dig_cnt_reg <= '0;
                        state_reg   <= COMMIT;
                    end else begin
                        dig_cnt_reg <= dig_cnt_reg + DW'(1);
                    end
                end
                DASH: begin
                    shadow_reg <= {NUM_DIGITS{SEG_DASH}};
                    state_reg  <= COMMIT;
                end
                COMMIT: begin
                    seg_reg   <= shadow_reg;
                    ovf_reg   <= ovf_path_reg;
                    busy_reg  <= 1'b0;
                    ready_reg <= 1'b1;
                    state_reg <= IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    ready_reg <= 1'b1;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

`ifdef HEX_SCORE_DISP_BLINK_EN
    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    logic [BW-1:0] blink_cnt_reg;
    logic          blink_off_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt_reg <= '0;
            blink_off_reg <= 1'b0;
        end else if (!blink) begin
            blink_cnt_reg <= '0;
            blink_off_reg <= 1'b0;
        end else if (blink_cnt_reg == BW'(BLINK_HALF - 1)) begin
            blink_cnt_reg <= '0;
            blink_off_reg <= ~blink_off_reg;
        end else begin
            blink_cnt_reg <= blink_cnt_reg + BW'(1);
        end
    end

    assign show = disp_en && !blink_off_reg;
`else
    assign show = disp_en;
`endif

    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_out
            assign seg_out[gi] = show ? seg_reg[gi] : SEG_BLANK;
        end
    endgenerate

    assign busy       = busy_reg;
    assign load_ready = ready_reg;
    assign overflow   = ovf_reg;

endmodule
